circ_buffer_ctrl: RTL and testbench

CIRC_BUFFER_CTRL -- requirements
Module: circ_buffer_ctrl

---
 rtl/circ_buffer_ctrl_pkg.sv | 18 +
 rtl/circ_buffer_ctrl_if.sv | 23 ++
 rtl/circ_buffer_ctrl_skid.sv | 68 ++++++
 rtl/circ_buffer_ctrl.sv | 167 ++++++++++++++++
 tb/tb_circ_buffer_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/circ_buffer_ctrl_pkg.sv
// channelizer_pkg: shared state encoding, size defaults and the power-of-2
// size check used by circ_buffer_ctrl and its sub-modules.
package channelizer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam int MIN_FFT_SIZE_DEFAULT = 8;

  // True when value has exactly one bit set.
  function automatic logic is_pow2(input logic [31:0] value);
    return (value != 32'd0) && ((value & (value - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/circ_buffer_ctrl_if.sv
// circ_buffer_ctrl_if: raw sample stream in, sequenced stream out.
// slave is the controller's view, master is the driving/receiving environment.
interface circ_buffer_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  s_axis_tvalid;
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tready;
  logic                  m_axis_tvalid;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tlast;
  logic                  m_axis_tready;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );
endinterface

// File: rtl/circ_buffer_ctrl_skid.sv
// axis_skid_buf: 2-entry registered skid buffer. Output comes straight from the
// head register (1-cycle latency); in_ready is a flop computed from the next
// occupancy, so there is no combinational path from out_ready to in_ready.
module axis_skid_buf
  import channelizer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic [1:0]       count_r;
  logic [1:0]       count_nxt_s;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] tail_r;
  logic             ready_r;
  logic             push_s;
  logic             pop_s;

  assign push_s = in_valid & ready_r;
  assign pop_s  = (count_r != 2'd0) & out_ready;

  // Occupancy after this edge's push and pop.
  always_comb begin
    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + 2'd1;
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - 2'd1;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Storage update; ready only while the buffer will have a free slot.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      count_r <= 2'd0;
      head_r  <= '0;
      tail_r  <= '0;
      ready_r <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      ready_r <= (count_nxt_s < 2'd2);
      case (count_r)
        2'd0: if (push_s) head_r <= in_data;
        2'd1: begin
          if (push_s && pop_s) head_r <= in_data;
          else if (push_s)     tail_r <= in_data;
        end
        2'd2: if (pop_s) head_r <= tail_r;
        default: ;
      endcase
    end
  end

  assign in_ready  = ready_r;
  assign out_valid = (count_r != 2'd0);
  assign out_data  = head_r;

endmodule

// File: rtl/circ_buffer_ctrl.sv
// circ_buffer_ctrl: tags each accepted sample with its phase within the
// current half-frame and tlast at the half boundary, and defers size changes
// until both halves of the circular buffer are complete.
// Optional: define CIRC_CTRL_FRAME_CNT_EN to add the frame_cnt output.
// fft_size reports the size of the beats currently leaving the block: it
// switches when the first-size-boundary beat is accepted downstream.
module circ_buffer_ctrl
  import channelizer_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int FFT_SIZE_WIDTH = 12,
  parameter int MIN_FFT_SIZE   = MIN_FFT_SIZE_DEFAULT
) (
  input  logic                      clk,
  input  logic                      sync_reset,
  circ_buffer_ctrl_if.slave         bus,
  input  logic [FFT_SIZE_WIDTH-1:0] cfg_fft_size,
  input  logic                      cfg_wr,
  output logic                      cfg_err,
  output logic [FFT_SIZE_WIDTH-2:0] phase,
  output logic [FFT_SIZE_WIDTH-1:0] fft_size,
`ifdef CIRC_CTRL_FRAME_CNT_EN
  output logic [31:0]               frame_cnt,
`endif
  output logic                      busy
);

  localparam int PW     = FFT_SIZE_WIDTH - 1;
  localparam int SKID_W = DATA_WIDTH + FFT_SIZE_WIDTH + 1;
  localparam logic [FFT_SIZE_WIDTH-1:0] MIN_SIZE = FFT_SIZE_WIDTH'(MIN_FFT_SIZE);
  localparam logic [FFT_SIZE_WIDTH-1:0] MAX_SIZE = {1'b1, {(FFT_SIZE_WIDTH-1){1'b0}}};

  state_e                    state_r;
  logic [FFT_SIZE_WIDTH-1:0] fft_size_r;
  logic [FFT_SIZE_WIDTH-1:0] shadow_r;
  logic [FFT_SIZE_WIDTH-1:0] fft_size_out_r;
  logic [PW-1:0]             phase_r;
  logic [PW-1:0]             half_m1_s;
  logic                      side_r;
  logic                      busy_r;
  logic                      cfg_err_r;
  logic                      cfg_ok_s;
  logic                      in_xfer_s;
  logic                      last_s;
  logic                      apply_s;
  logic                      skid_ready_s;
  logic                      skid_valid_s;
  logic                      out_xfer_s;
  logic                      out_mark_s;
  logic [SKID_W-1:0]         skid_in_s;
  logic [SKID_W-1:0]         skid_out_s;

  assign cfg_ok_s  = is_pow2(32'(cfg_fft_size)) && (cfg_fft_size >= MIN_SIZE) &&
                     (cfg_fft_size <= MAX_SIZE);
  assign bus.s_axis_tready = skid_ready_s & (state_r != S_IDLE);
  assign in_xfer_s = bus.s_axis_tvalid & bus.s_axis_tready;
  assign half_m1_s = fft_size_r[FFT_SIZE_WIDTH-1:1] - PW'(1);
  assign last_s    = (phase_r == half_m1_s);
  // The beat that closes the second half while a resize is pending.
  assign apply_s   = (state_r == S_DRAIN) & last_s & side_r;
  assign skid_in_s = {apply_s, last_s, phase_r, bus.s_axis_tdata};

  axis_skid_buf #(.WIDTH(SKID_W)) u_skid (
    .clk        (clk),
    .sync_reset (sync_reset),
    .in_valid   (in_xfer_s),
    .in_data    (skid_in_s),
    .in_ready   (skid_ready_s),
    .out_valid  (skid_valid_s),
    .out_data   (skid_out_s),
    .out_ready  (bus.m_axis_tready)
  );

  assign bus.m_axis_tvalid = skid_valid_s;
  assign bus.m_axis_tdata  = skid_out_s[DATA_WIDTH-1:0];
  assign phase             = skid_out_s[DATA_WIDTH +: PW];
  assign bus.m_axis_tlast  = skid_out_s[DATA_WIDTH+PW];
  assign out_mark_s        = skid_out_s[DATA_WIDTH+PW+1];
  assign out_xfer_s        = skid_valid_s & bus.m_axis_tready;

  // Control FSM: config acceptance, phase/side sequencing, deferred resize.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_r        <= S_IDLE;
      fft_size_r     <= '0;
      shadow_r       <= '0;
      fft_size_out_r <= '0;
      phase_r        <= '0;
      side_r         <= 1'b0;
      busy_r         <= 1'b0;
      cfg_err_r      <= 1'b0;
    end else begin
      cfg_err_r <= cfg_wr & ~cfg_ok_s;
      if (out_xfer_s && out_mark_s) fft_size_out_r <= fft_size_r;
      case (state_r)
        S_IDLE: begin
          if (cfg_wr && cfg_ok_s) begin
            fft_size_r     <= cfg_fft_size;
            fft_size_out_r <= cfg_fft_size;
            phase_r        <= '0;
            side_r         <= 1'b0;
            state_r        <= S_RUN;
          end
        end
        S_RUN: begin
          if (in_xfer_s) begin
            phase_r <= last_s ? '0 : phase_r + PW'(1);
            side_r  <= side_r ^ last_s;
          end
          if (cfg_wr && cfg_ok_s) begin
            shadow_r <= cfg_fft_size;
            busy_r   <= 1'b1;
            state_r  <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (in_xfer_s && apply_s) begin
            fft_size_r <= shadow_r;
            phase_r    <= '0;
            side_r     <= 1'b0;
            // A write landing on the applying beat queues against the new size.
            if (cfg_wr && cfg_ok_s) begin
              shadow_r <= cfg_fft_size;
            end else begin
              busy_r  <= 1'b0;
              state_r <= S_RUN;
            end
          end else begin
            if (in_xfer_s) begin
              phase_r <= last_s ? '0 : phase_r + PW'(1);
              side_r  <= side_r ^ last_s;
            end
            if (cfg_wr && cfg_ok_s) shadow_r <= cfg_fft_size;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CIRC_CTRL_FRAME_CNT_EN
  logic [31:0] frame_cnt_r;

  // Count downstream tlast beats; restart on every applied size.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      frame_cnt_r <= 32'd0;
    end else if ((state_r == S_IDLE) && cfg_wr && cfg_ok_s) begin
      frame_cnt_r <= 32'd0;
    end else if (out_xfer_s && out_mark_s) begin
      frame_cnt_r <= 32'd0;
    end else if (out_xfer_s && bus.m_axis_tlast) begin
      frame_cnt_r <= frame_cnt_r + 32'd1;
    end
  end

  assign frame_cnt = frame_cnt_r;
`endif

  assign cfg_err  = cfg_err_r;
  assign fft_size = fft_size_out_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_circ_buffer_ctrl.sv
// tb_circ_buffer_ctrl: table vectors, directed corner sequences and random
// traffic checked against a frame-arithmetic reference model.
module tb_circ_buffer_ctrl;
  localparam int DW = 32;
  localparam int FW = 12;

  logic          clk = 1'b0;
  logic          sync_reset;
  logic [FW-1:0] cfg_fft_size;
  logic          cfg_wr;
  logic          cfg_err;
  logic [FW-2:0] phase;
  logic [FW-1:0] fft_size;
  logic          busy;
`ifdef CIRC_CTRL_FRAME_CNT_EN
  logic [31:0]   frame_cnt;
`endif

  always #5 clk = ~clk;

  circ_buffer_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  circ_buffer_ctrl #(.DATA_WIDTH(DW), .FFT_SIZE_WIDTH(FW), .MIN_FFT_SIZE(8)) dut (
    .clk          (clk),
`ifdef CIRC_CTRL_FRAME_CNT_EN
    .frame_cnt    (frame_cnt),
`endif
    .sync_reset   (sync_reset),
    .bus          (bus),
    .cfg_fft_size (cfg_fft_size),
    .cfg_wr       (cfg_wr),
    .cfg_err      (cfg_err),
    .phase        (phase),
    .fft_size     (fft_size),
    .busy         (busy)
  );

  typedef struct {
    logic [31:0] d;
    int          ph;
    bit          last;
    bit          apply;
    int          nsize;
  } beat_t;

  typedef struct {
    int size;
    bit err;
  } cfg_vec_t;

  beat_t    exp_q[$];
  cfg_vec_t cfg_tab[9];
  int checks = 0;
  int failures = 0;
  // Reference model: samples in the current size epoch, active/pending sizes.
  int m_size, m_out_size, m_pend_size, m_idx, outstanding;
  bit m_run, m_pend;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit size_ok(input int sz);
    return (sz >= 8) && (sz <= 2048) && ((sz & (sz - 1)) == 0);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    outstanding = 0; m_run = 0; m_pend = 0;
    m_size = 0; m_out_size = 0; m_pend_size = 0; m_idx = 0;
  endtask

  task automatic model_sample(input logic [31:0] d);
    beat_t b;
    int half, halfno;
    half   = m_size / 2;
    b.d    = d;
    b.ph   = m_idx % half;
    b.last = (b.ph == half - 1);
    halfno = m_idx / half;
    b.apply = m_pend && b.last && (halfno % 2 == 1);
    b.nsize = m_pend_size;
    exp_q.push_back(b);
    outstanding++;
    m_idx++;
    if (b.apply) begin
      m_size = m_pend_size; m_pend = 0; m_idx = 0;
    end
  endtask

  task automatic model_pop();
    beat_t b;
    if (exp_q.size() == 0) begin
      chk("unexpected_beat", 1, 0);
    end else begin
      b = exp_q.pop_front();
      chk("beat_data", bus.m_axis_tdata, b.d);
      chk("beat_phase", phase, b.ph);
      chk("beat_tlast", bus.m_axis_tlast, b.last);
      if (b.apply) m_out_size = b.nsize;
    end
    outstanding--;
  endtask

  function automatic bit model_cfg(input int sz);
    if (!size_ok(sz)) return 1'b0;
    if (!m_run) begin
      m_run = 1; m_size = sz; m_out_size = sz; m_idx = 0;
    end else begin
      m_pend = 1; m_pend_size = sz;
    end
    return 1'b1;
  endfunction

  // One clock: account for handshakes at the coming edge, then check at negedge.
  task automatic step();
    bit exp_err;
    exp_err = 0;
    if (sync_reset) begin
      model_reset();
    end else begin
      if (bus.m_axis_tvalid && bus.m_axis_tready) model_pop();
      if (bus.s_axis_tvalid && bus.s_axis_tready) model_sample(bus.s_axis_tdata);
      if (cfg_wr) exp_err = !model_cfg(int'(cfg_fft_size));
    end
    @(negedge clk);
    chk("m_tvalid", bus.m_axis_tvalid, outstanding != 0);
    chk("fft_size", fft_size, m_out_size);
    chk("busy", busy, m_pend);
    chk("cfg_err", cfg_err, exp_err);
    if (!m_run) chk("s_tready_idle", bus.s_axis_tready, 0);
    if (outstanding >= 2) chk("s_tready_full", bus.s_axis_tready, 0);
  endtask

  task automatic send(input logic [31:0] d);
    bit acc;
    acc = 0;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = bus.s_axis_tready;
      step();
    end
    bus.s_axis_tvalid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic cfg_pulse(input int sz);
    cfg_fft_size = FW'(sz);
    cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic drain();
    bus.m_axis_tready = 1'b1;
    for (int i = 0; i < 50 && outstanding != 0; i++) step();
    chk("drain", outstanding, 0);
  endtask

  task automatic do_reset();
    sync_reset = 1'b1;
    step();
    step();
    sync_reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    cfg_tab[0] = '{12, 1};   cfg_tab[1] = '{4, 1};    cfg_tab[2] = '{16, 0};
    cfg_tab[3] = '{2048, 0}; cfg_tab[4] = '{1, 1};    cfg_tab[5] = '{2047, 1};
    cfg_tab[6] = '{3000, 1}; cfg_tab[7] = '{0, 1};    cfg_tab[8] = '{8, 0};

    bus.s_axis_tvalid = 1'b0; bus.s_axis_tdata = '0; bus.m_axis_tready = 1'b1;
    cfg_fft_size = '0; cfg_wr = 1'b0;
    model_reset();

    // Reset values
    do_reset();
    chk("rst_tdata", bus.m_axis_tdata, 0);
    chk("rst_tlast", bus.m_axis_tlast, 0);
    chk("rst_phase", phase, 0);
    chk("rst_tready", bus.s_axis_tready, 0);

    // Illegal sizes in idle: error pulse, stay idle
    cfg_pulse(12);
    chk("idle_err12", cfg_err, 1);
    cfg_pulse(4);
    chk("idle_err4", cfg_err, 1);
    step();
    chk("err_one_cycle", cfg_err, 0);
    chk("idle_size", fft_size, 0);

    // Size 16, 24 samples, tready high
    cfg_pulse(16);
    for (int i = 0; i < 24; i++) send(32'h1000 + 32'(i));
    drain();

    // Resize 16 -> 64 requested after sample 3
    do_reset();
    cfg_pulse(16);
    for (int i = 0; i < 3; i++) send(32'h2000 + 32'(i));
    cfg_pulse(64);
    chk("resize_busy_on", busy, 1);
    for (int i = 3; i < 20; i++) send(32'h2000 + 32'(i));
    drain();
    chk("resize_size", fft_size, 64);
    chk("resize_busy_off", busy, 0);

    // Table of cfg writes while running
    for (int i = 0; i < 9; i++) begin
      cfg_pulse(cfg_tab[i].size);
      chk("cfg_tab_err", cfg_err, cfg_tab[i].err);
    end
    for (int i = 0; i < 64; i++) send(32'h3000 + 32'(i));
    drain();
    chk("tab_last_wins", fft_size, 8);
    chk("tab_busy_off", busy, 0);

    // cfg_wr on the applying beat queues against the new size
    do_reset();
    cfg_pulse(8);
    cfg_pulse(16);
    for (int i = 0; i < 7; i++) send(32'h4000 + 32'(i));
    cfg_fft_size = FW'(32);
    cfg_wr = 1'b1;
    send(32'h4007);
    cfg_wr = 1'b0;
    drain();
    chk("coincide_size", fft_size, 16);
    chk("coincide_busy", busy, 1);
    for (int i = 0; i < 16; i++) send(32'h4100 + 32'(i));
    drain();
    chk("coincide_final", fft_size, 32);
    chk("coincide_idle", busy, 0);

    // Random backpressure, size 2048
    do_reset();
    cfg_pulse(2048);
    sent = 0;
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      bus.m_axis_tready = 1'($urandom_range(0, 1));
      bus.s_axis_tvalid = ($urandom_range(0, 3) != 0);
      bus.s_axis_tdata  = $urandom;
      if (bus.s_axis_tvalid && bus.s_axis_tready) sent++;
      step();
    end
    bus.s_axis_tvalid = 1'b0;
    chk("rand_sent", sent, 1000);
    drain();

    // Reset with beats held under backpressure
    do_reset();
    cfg_pulse(16);
    bus.m_axis_tready = 1'b0;
    bus.s_axis_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.s_axis_tdata = 32'h5000 + 32'(i);
      step();
    end
    sync_reset = 1'b1;
    step();
    sync_reset = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b1;
    chk("mid_rst_tdata", bus.m_axis_tdata, 0);
    chk("mid_rst_tlast", bus.m_axis_tlast, 0);
    chk("mid_rst_phase", phase, 0);
    for (int i = 0; i < 20; i++) step();

`ifdef CIRC_CTRL_FRAME_CNT_EN
    // Frame counter: 40 samples of size 8, then a resize
    do_reset();
    cfg_pulse(8);
    for (int i = 0; i < 40; i++) send(32'h6000 + 32'(i));
    drain();
    chk("frame_cnt_10", frame_cnt, 10);
    cfg_pulse(16);
    for (int i = 0; i < 8; i++) send(32'h6100 + 32'(i));
    drain();
    chk("frame_cnt_clr", frame_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
